operand_entry: RTL

Keypad-to-operand front end for the calculator datapath. Consumes one key code per `key_valid` pulse and builds two sign-magnitude operands, X and Y, plus the add/subtract select. Presents them to the downstream sign-magnitude adder/subtractor (9-bit operands, bit 8 = sign, bits 7:0 = magnitude) through a valid/ack handshake. Holds the operands stable until the adder side acknowledges.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/entry_operand.sv | 51 +++++
 rtl/operand_entry.sv | 113 +++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end and the sign-magnitude adder.
package calc_pkg;

  // Magnitude width; operands carry one extra sign bit on top.
  localparam int N_MAG = 8;
  localparam int OP_W  = N_MAG + 1;

  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_EQ    = 4'd12;
  localparam logic [3:0] KEY_NEG   = 4'd13;
  localparam logic [3:0] KEY_CLR   = 4'd14;

  typedef enum logic [1:0] {
    ENTER_X = 2'd0,
    ENTER_Y = 2'd1,
    PRESENT = 2'd2
  } entry_state_t;

endpackage

// File: rtl/entry_operand.sv
// One decimal operand: magnitude, sign and digit count, with a sign-magnitude output.
module entry_operand #(
  parameter int N    = 8,
  parameter int MAXD = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [3:0]   i_digit,
  input  logic         i_tog,
  output logic [N:0]   o_val,
  output logic         o_empty,
  output logic         o_ovf
);

  localparam int CW = $clog2(MAXD + 1);

  logic [N-1:0]  r_mag;
  logic          r_sign;
  logic [CW-1:0] r_cnt;
  logic          w_full;

  assign w_full  = (r_cnt == CW'(MAXD));
  assign o_ovf   = i_push && w_full;
  assign o_empty = (r_cnt == '0);
  // Sign is suppressed on a zero magnitude so -0 never leaves this block.
  assign o_val   = {r_sign && (r_mag != '0), r_mag};

  // Accumulate digits, toggle sign; clear wins over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag  <= '0;
      r_sign <= 1'b0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_mag  <= '0;
      r_sign <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (i_push && !w_full) begin
        r_mag <= (r_mag * N'(10)) + N'(i_digit);
        r_cnt <= r_cnt + CW'(1);
      end
      if (i_tog) begin
        r_sign <= !r_sign;
      end
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Keypad front end: builds X, Y and the add/subtract select, then holds them for the adder.
//
// state   | meaning
// ENTER_X | collecting digits/sign for X
// ENTER_Y | collecting digits/sign for Y, operator may still change
// PRESENT | operands valid and frozen until op_ack
module operand_entry
  import calc_pkg::*;
#(
  parameter int N            = calc_pkg::N_MAG,
  parameter int MAX_X_DIGITS = 2,
  parameter int MAX_Y_DIGITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       op_ack,
  output logic [N:0] X,
  output logic [N:0] Y,
  output logic       min_en,
  output logic       op_valid,
  output logic       key_ready,
  output logic       entry_err
);

  entry_state_t r_state, w_state_n;
  logic r_min_en, w_min_en_n;
  logic r_err, w_err_n;
  logic w_clr;
  logic w_push_x, w_push_y, w_tog_x, w_tog_y;
  logic w_ovf_x, w_ovf_y;
  logic w_empty_x, w_empty_y;

  entry_operand #(.N(N), .MAXD(MAX_X_DIGITS)) u_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_push  (w_push_x),
    .i_digit (key_code),
    .i_tog   (w_tog_x),
    .o_val   (X),
    .o_empty (w_empty_x),
    .o_ovf   (w_ovf_x)
  );

  entry_operand #(.N(N), .MAXD(MAX_Y_DIGITS)) u_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_push  (w_push_y),
    .i_digit (key_code),
    .i_tog   (w_tog_y),
    .o_val   (Y),
    .o_empty (w_empty_y),
    .o_ovf   (w_ovf_y)
  );

  // State, operator select and sticky error; digit overflow folds into the error here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ENTER_X;
      r_min_en <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_min_en <= w_min_en_n;
      r_err    <= w_clr ? 1'b0 : (w_err_n | w_ovf_x | w_ovf_y);
    end
  end

  // Key decode and next-state; CLEAR and op_ack both collapse to the reset values.
  always_comb begin
    w_state_n  = r_state;
    w_min_en_n = r_min_en;
    w_err_n    = r_err;
    w_clr      = 1'b0;
    w_push_x   = 1'b0;
    w_push_y   = 1'b0;
    w_tog_x    = 1'b0;
    w_tog_y    = 1'b0;
    if ((key_valid && key_code == KEY_CLR) || (r_state == PRESENT && op_ack)) begin
      w_clr      = 1'b1;
      w_state_n  = ENTER_X;
      w_min_en_n = 1'b0;
      w_err_n    = 1'b0;
    end else if (key_valid && r_state != PRESENT) begin
      if (key_code <= 4'd9) begin
        w_push_x = (r_state == ENTER_X);
        w_push_y = (r_state == ENTER_Y);
      end else if (key_code == KEY_NEG) begin
        w_tog_x = (r_state == ENTER_X);
        w_tog_y = (r_state == ENTER_Y);
      end else if (key_code == KEY_PLUS || key_code == KEY_MINUS) begin
        w_min_en_n = (key_code == KEY_MINUS);
        w_state_n  = ENTER_Y;
      end else if (key_code == KEY_EQ) begin
        if (r_state == ENTER_Y) begin
          if (w_empty_y) w_err_n = 1'b1;
          else           w_state_n = PRESENT;
        end
      end else begin
        w_err_n = 1'b1;
      end
    end
  end

  assign min_en    = r_min_en;
  assign op_valid  = (r_state == PRESENT);
  assign key_ready = (r_state != PRESENT);
  assign entry_err = r_err;

endmodule
